light_manager_mc: RTL and testbench

//   Multi-channel successor of the single-channel encoder-driven dimmer.

---
 rtl/lm_pkg.sv | 29 ++
 rtl/lm_channel.sv | 82 ++++++++
 rtl/light_manager_mc.sv | 101 ++++++++++
 tb/tb_light_manager_mc.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lm_pkg
//  Purpose  : Shared helpers for the multi-channel light manager
//             (bit-width and full-scale value computation).
//  Revision : 1.0 - initial release
// ============================================================================
package lm_pkg;

  // Number of bits needed to hold the values 0..value-1 (0 for value<=1)
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

  // Full-scale value of a w-bit unsigned quantity
  function automatic int LM_MAX(input int w);
    return (1 << w) - 1;
  endfunction

endpackage : lm_pkg
`default_nettype wire

// File: rtl/lm_channel.sv
`default_nettype none
// ============================================================================
//  Module   : lm_channel
//  Purpose  : One brightness channel: saturating target register, duty
//             ramp toward the target and registered PWM comparator.
//  Revision : 1.0 - initial release
// ============================================================================
module lm_channel
  import lm_pkg::*;
#(
  parameter int PWM_W = 8,
  parameter int STEP  = 5
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             edit_inc,
  input  logic             edit_dec,
  input  logic             tick,
  input  logic             fade_en,
  input  logic [PWM_W-1:0] cnt,
  output logic [PWM_W-1:0] tgt,
  output logic             pwm
);

  // One extra bit so target+STEP can be compared against full scale
  localparam logic [PWM_W:0] C_STEP = (PWM_W+1)'(STEP);
  localparam logic [PWM_W:0] C_MAX  = (PWM_W+1)'(LM_MAX(PWM_W));

  logic [PWM_W-1:0] r_tgt;
  logic [PWM_W-1:0] r_duty;
  logic             r_pwm;
  logic [PWM_W:0]   w_sum;
  logic [PWM_W-1:0] w_inc_val;
  logic [PWM_W-1:0] w_dec_val;

  // Saturating next-target candidates for a raise and for a lower
  always_comb begin
    w_sum     = {1'b0, r_tgt} + C_STEP;
    w_inc_val = (w_sum > C_MAX) ? C_MAX[PWM_W-1:0] : w_sum[PWM_W-1:0];
    w_dec_val = ({1'b0, r_tgt} >= C_STEP) ? (r_tgt - C_STEP[PWM_W-1:0]) : '0;
  end

  // Target register: opposing pulses in the same cycle cancel out
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_tgt <= '0;
    end else if (edit_inc && !edit_dec) begin
      r_tgt <= w_inc_val;
    end else if (edit_dec && !edit_inc) begin
      r_tgt <= w_dec_val;
    end
  end

  // Duty follows the target directly, or one LSB per ramp tick when fading
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_duty <= '0;
    end else if (!fade_en) begin
      r_duty <= r_tgt;
    end else if (tick) begin
      if (r_duty < r_tgt) begin
        r_duty <= r_duty + 1'b1;
      end else if (r_duty > r_tgt) begin
        r_duty <= r_duty - 1'b1;
      end
    end
  end

  // PWM compare; counter never reaches full scale so max duty is always on
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (r_duty > cnt);
    end
  end

  assign tgt = r_tgt;
  assign pwm = r_pwm;

endmodule : lm_channel
`default_nettype wire

// File: rtl/light_manager_mc.sv
`default_nettype none
// ============================================================================
//  Module   : light_manager_mc
//  Purpose  : Multi-channel encoder-driven LED dimmer. Holds NUM_CH targets,
//             edits the selected one, fades each duty and drives one PWM
//             output per channel from a shared counter.
//  Revision : 1.0 - initial release
// ============================================================================
module light_manager_mc
  import lm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PWM_W    = 8,
  parameter int STEP     = 5,
  parameter int RAMP_DIV = 1000
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     inc_i,
  input  logic                     dec_i,
  input  logic                     sel_i,
  input  logic                     fade_en_i,
  output logic [NUM_CH-1:0]        pwm_o,
  output logic [clog2(NUM_CH)-1:0] sel_ch_o,
  output logic [PWM_W-1:0]         sel_tgt_o
);

  localparam int SEL_W = clog2(NUM_CH);
  // RAMP_DIV=1 still needs a one-bit prescaler that simply stays at zero
  localparam int PRE_W = (clog2(RAMP_DIV) < 1) ? 1 : clog2(RAMP_DIV);

  localparam logic [SEL_W-1:0] C_SEL_LAST = SEL_W'(NUM_CH - 1);
  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [PWM_W-1:0] C_CNT_LAST = PWM_W'(LM_MAX(PWM_W) - 1);

  logic [SEL_W-1:0] r_sel;
  logic [PRE_W-1:0] r_pre;
  logic [PWM_W-1:0] r_cnt;
  logic             w_tick;
  logic [PWM_W-1:0] w_tgt [NUM_CH];
  logic [NUM_CH-1:0] w_pwm;

  // Selected-channel index, wrapping after the last channel
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_sel <= '0;
    end else if (sel_i) begin
      r_sel <= (r_sel == C_SEL_LAST) ? '0 : r_sel + 1'b1;
    end
  end

  // Ramp prescaler: one tick every RAMP_DIV cycles
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else begin
      r_pre <= (r_pre == C_PRE_LAST) ? '0 : r_pre + 1'b1;
    end
  end

  assign w_tick = (r_pre == C_PRE_LAST);

  // Shared PWM counter with period 2^PWM_W-1 so full-scale duty is solid on
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= (r_cnt == C_CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Per-channel instances; edit pulses reach only the selected channel
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic w_edit_inc;
    logic w_edit_dec;

    assign w_edit_inc = inc_i & (r_sel == SEL_W'(k));
    assign w_edit_dec = dec_i & (r_sel == SEL_W'(k));

    lm_channel #(
      .PWM_W (PWM_W),
      .STEP  (STEP)
    ) u_ch (
      .clk_i    (clk_i),
      .rst      (rst),
      .edit_inc (w_edit_inc),
      .edit_dec (w_edit_dec),
      .tick     (w_tick),
      .fade_en  (fade_en_i),
      .cnt      (r_cnt),
      .tgt      (w_tgt[k]),
      .pwm      (w_pwm[k])
    );
  end

  assign pwm_o     = w_pwm;
  assign sel_ch_o  = r_sel;
  assign sel_tgt_o = w_tgt[r_sel];

endmodule : light_manager_mc
`default_nettype wire

// File: tb/tb_light_manager_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_light_manager_mc
//  Purpose  : Self-checking bench for light_manager_mc (4 ch, 8-bit, STEP 5,
//             RAMP_DIV 4): edit table, PWM duty counts, fade corners,
//             asynchronous reset and a long random stream against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_light_manager_mc;

  localparam int NUM_CH   = 4;
  localparam int PWM_W    = 8;
  localparam int STEP     = 5;
  localparam int RAMP_DIV = 4;
  localparam int MAXV     = 255;

  logic        clk_i = 1'b0;
  logic        rst   = 1'b1;
  logic        inc_i = 1'b0;
  logic        dec_i = 1'b0;
  logic        sel_i = 1'b0;
  logic        fade_en_i = 1'b0;
  logic [3:0]  pwm_o;
  logic [1:0]  sel_ch_o;
  logic [7:0]  sel_tgt_o;

  light_manager_mc #(
    .NUM_CH   (NUM_CH),
    .PWM_W    (PWM_W),
    .STEP     (STEP),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .inc_i     (inc_i),
    .dec_i     (dec_i),
    .sel_i     (sel_i),
    .fade_en_i (fade_en_i),
    .pwm_o     (pwm_o),
    .sel_ch_o  (sel_ch_o),
    .sel_tgt_o (sel_tgt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_tgt [4];
  int m_duty[4];
  int m_sel, m_pre, m_cnt;

  typedef struct {
    logic [3:0] pwm;
    int         sel;
    int         tgt;
    int         duty[4];
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic inc, dec, sel, fade;
    int   exp_sel;
    int   exp_tgt;
  } vec_t;
  vec_t tbl[11];

  int prev_d;
  bit dir_ok;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int get_duty(input int k);
    case (k)
      0:       return int'(dut.g_ch[0].u_ch.r_duty);
      1:       return int'(dut.g_ch[1].u_ch.r_duty);
      2:       return int'(dut.g_ch[2].u_ch.r_duty);
      default: return int'(dut.g_ch[3].u_ch.r_duty);
    endcase
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 4; k++) begin
      m_tgt[k]  = 0;
      m_duty[k] = 0;
    end
    m_sel = 0;
    m_pre = 0;
    m_cnt = 0;
    sb.delete();
  endtask

  // Drive one cycle, predict its result, then compare after the edge
  task automatic step(input logic i, input logic d, input logic s, input logic f);
    exp_t e, got;
    int   n_tgt[4];
    bit   tick;
    inc_i = i; dec_i = d; sel_i = s; fade_en_i = f;
    tick  = (m_pre == RAMP_DIV - 1);
    n_tgt = m_tgt;
    if (i && !d) n_tgt[m_sel] = (m_tgt[m_sel] + STEP > MAXV) ? MAXV : m_tgt[m_sel] + STEP;
    if (d && !i) n_tgt[m_sel] = (m_tgt[m_sel] < STEP) ? 0 : m_tgt[m_sel] - STEP;
    for (int k = 0; k < 4; k++) begin
      e.pwm[k] = (m_duty[k] > m_cnt);
      if (!f)                           e.duty[k] = m_tgt[k];
      else if (tick && m_duty[k] < m_tgt[k]) e.duty[k] = m_duty[k] + 1;
      else if (tick && m_duty[k] > m_tgt[k]) e.duty[k] = m_duty[k] - 1;
      else                              e.duty[k] = m_duty[k];
    end
    e.sel = s ? ((m_sel == NUM_CH - 1) ? 0 : m_sel + 1) : m_sel;
    e.tgt = n_tgt[e.sel];
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    got = sb.pop_front();
    check("pwm_o", int'(pwm_o), int'(got.pwm));
    check("sel_ch_o", int'(sel_ch_o), got.sel);
    check("sel_tgt_o", int'(sel_tgt_o), got.tgt);
    for (int k = 0; k < 4; k++) check($sformatf("duty%0d", k), get_duty(k), got.duty[k]);
    m_tgt  = n_tgt;
    m_duty = got.duty;
    m_sel  = got.sel;
    m_pre  = tick ? 0 : m_pre + 1;
    m_cnt  = (m_cnt == MAXV - 1) ? 0 : m_cnt + 1;
    inc_i = 1'b0; dec_i = 1'b0; sel_i = 1'b0;
  endtask

  // Step while checking channel 2 duty moves only in the allowed direction
  task automatic mon_step(input logic i, input logic d, input int dir);
    int cur;
    step(i, d, 1'b0, 1'b1);
    cur = get_duty(2);
    if (dir > 0 && !(cur == prev_d || cur == prev_d + 1)) dir_ok = 1'b0;
    if (dir < 0 && !(cur == prev_d || cur == prev_d - 1)) dir_ok = 1'b0;
    prev_d = cur;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inc_i = 1'b0; dec_i = 1'b0; sel_i = 1'b0; fade_en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst = 1'b0;
    reset_model();
  endtask

  // Count high cycles of one output bit over one full PWM period
  task automatic count_high(input int bitn, output int hi);
    hi = 0;
    for (int c = 0; c < MAXV; c++) begin
      step(1'b0, 1'b0, 1'b0, fade_en_i);
      if (pwm_o[bitn]) hi++;
    end
  endtask

  initial begin
    int hi, hi_other, cyc;

    //             inc   dec   sel   fade  sel tgt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  5};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 10};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 15};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 15};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  5};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2,  0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3,  0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 20};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 20};

    do_reset();
    check("reset_pwm", int'(pwm_o), 0);
    check("reset_sel", int'(sel_ch_o), 0);
    check("reset_tgt", int'(sel_tgt_o), 0);
    for (int k = 0; k < 4; k++) check($sformatf("reset_duty%0d", k), get_duty(k), 0);

    // Three raises on ch0, then one PWM period should show 15 high cycles
    for (int v = 0; v < 3; v++) begin
      step(tbl[v].inc, tbl[v].dec, tbl[v].sel, tbl[v].fade);
      check($sformatf("tbl%0d_sel", v), int'(sel_ch_o), tbl[v].exp_sel);
      check($sformatf("tbl%0d_tgt", v), int'(sel_tgt_o), tbl[v].exp_tgt);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    hi = 0; hi_other = 0;
    for (int c = 0; c < MAXV; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (pwm_o[0]) hi++;
      if (pwm_o[3:1] != 3'b000) hi_other++;
    end
    check("pwm0_high_15", hi, 15);
    check("pwm_others_low", hi_other, 0);

    // Remaining edit vectors: cancel, select+edit, wrap
    for (int v = 3; v < 11; v++) begin
      step(tbl[v].inc, tbl[v].dec, tbl[v].sel, tbl[v].fade);
      check($sformatf("tbl%0d_sel", v), int'(sel_ch_o), tbl[v].exp_sel);
      check($sformatf("tbl%0d_tgt", v), int'(sel_tgt_o), tbl[v].exp_tgt);
    end

    // Upper saturation on ch0 (currently 20)
    repeat (46) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("tgt_250", int'(sel_tgt_o), 250);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_255", int'(sel_tgt_o), 255);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_hold_255", int'(sel_tgt_o), 255);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    count_high(0, hi);
    check("pwm0_full_on", hi, 255);

    // Lower saturation on ch1 (currently 5)
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("dec_to_0", int'(sel_tgt_o), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("dec_hold_0", int'(sel_tgt_o), 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    count_high(1, hi);
    check("pwm1_full_off", hi, 0);

    // Fade ramp on ch2: 0 -> 20, one LSB per 4-cycle tick
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    prev_d = 0; dir_ok = 1'b1; cyc = 0;
    repeat (4) begin mon_step(1'b1, 1'b0, 1); cyc++; end
    while (get_duty(2) != 20 && cyc < 200) begin mon_step(1'b0, 1'b0, 1); cyc++; end
    check("ramp_reach_20", get_duty(2), 20);
    check("ramp_time_80pm4", int'(cyc >= 76 && cyc <= 84), 1);
    check("ramp_monotonic_up", int'(dir_ok), 1);

    // Retarget down to 10, expect no overshoot
    mon_step(1'b0, 1'b1, -1);
    mon_step(1'b0, 1'b1, -1);
    cyc = 0;
    while (get_duty(2) != 10 && cyc < 200) begin mon_step(1'b0, 1'b0, -1); cyc++; end
    repeat (12) mon_step(1'b0, 1'b0, -1);
    check("ramp_down_10", get_duty(2), 10);
    check("ramp_monotonic_down", int'(dir_ok), 1);

    // Reverse mid-ramp: head for 30, retarget to 10 at duty 15
    repeat (4) mon_step(1'b1, 1'b0, 1);
    cyc = 0;
    while (get_duty(2) != 15 && cyc < 200) begin mon_step(1'b0, 1'b0, 1); cyc++; end
    check("reach_15", get_duty(2), 15);
    repeat (4) mon_step(1'b0, 1'b1, 0);
    dir_ok = 1'b1;
    cyc = 0;
    while (get_duty(2) != 10 && cyc < 200) begin mon_step(1'b0, 1'b0, -1); cyc++; end
    repeat (12) mon_step(1'b0, 1'b0, -1);
    check("reverse_to_10", get_duty(2), 10);
    check("reverse_monotonic", int'(dir_ok), 1);

    // Fade 1->0 mid-ramp snaps to target; 0->1 keeps duty
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("midramp_below_40", int'(get_duty(2) < 40), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("snap_to_40", get_duty(2), 40);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("no_jump_40", get_duty(2), 40);

    // Asynchronous reset while pwm_o[2] is high, between clock edges
    cyc = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    while (!pwm_o[2] && cyc < 300) begin step(1'b0, 1'b0, 1'b0, 1'b0); cyc++; end
    check("pwm2_high_before_rst", int'(pwm_o[2]), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", int'(pwm_o), 0);
    check("async_rst_sel", int'(sel_ch_o), 0);
    check("async_rst_tgt", int'(sel_tgt_o), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst = 1'b0;
    reset_model();

    // Random edit/select/fade stream against the model
    begin
      logic rf;
      rf = 1'b0;
      for (int c = 0; c < 10000; c++) begin
        if ($urandom_range(0, 199) == 0) rf = ~rf;
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0), rf);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_light_manager_mc
`default_nettype wire
